// File: rtl/buart_pkg.sv
// Shared constants, FSM state types and parity helper for the FIFO-buffered byte UART.
package buart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned ERR_FRAME = 0;
    localparam int unsigned ERR_PAR   = 1;
    localparam int unsigned ERR_OVR   = 2;
    localparam int unsigned ERR_W     = 3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    // Parity bit that makes data+parity even (or odd) weight.
    function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/buart_sfifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; storage is not reset.
module buart_sfifo
    import buart_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/buart_fifo_gen.sv
// Byte UART with RX/TX FIFOs, optional parity, false-start rejection and sticky error flags.
module buart_fifo_gen
    import buart_pkg::*;
#(
    parameter int unsigned FREQ_MHZ = 12,
    parameter int unsigned BAUDS    = 115200,
    parameter int unsigned RX_AW    = 3,
    parameter int unsigned TX_AW    = 3,
    parameter int unsigned PARITY   = 0
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             rx,
    output logic             tx,
    input  logic             wr,
    input  logic [7:0]       tx_data,
    input  logic             rd,
    output logic [7:0]       rx_data,
    output logic             valid,
    output logic             busy,
    output logic             tx_idle,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err
);

    localparam int unsigned DIV  = (FREQ_MHZ * 1000000) / BAUDS;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned NB   = (PARITY == PARITY_NONE) ? 10 : 11;

    logic rx_m, rx_s;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shr_q, rx_shr_d;
    logic             rx_par_q, rx_par_d;
    logic             rx_half, rx_full_tick, rx_par_ok;
    logic             rx_push, rx_pop, rx_empty, rx_full;
    logic [ERR_W-1:0] err_set, err_q;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [10:0]      tx_frm_q, tx_frm_d;
    logic [10:0]      tx_load;
    logic [7:0]       tx_head;
    logic             tx_end_bit, tx_end_frm;
    logic             tx_push, tx_pop, tx_empty, tx_full;

    // Two-flop synchroniser, idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shr_q   <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shr_q   <= rx_shr_d;
            rx_par_q   <= rx_par_d;
        end
    end

    assign rx_half      = (rx_cnt_q == CW'(HALF - 1));
    assign rx_full_tick = (rx_cnt_q == CW'(DIV - 1));
    assign rx_par_ok    = (PARITY == PARITY_NONE) || (rx_par_q == parity_bit(rx_shr_q, PARITY));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shr_d   = rx_shr_q;
        rx_par_d   = rx_par_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_full_tick) begin
                    rx_cnt_d = '0;
                    rx_shr_d = {rx_s, rx_shr_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
                    end
                end
            end
            RX_PAR: begin
                if (rx_full_tick) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_full_tick) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Stop-bit verdict: frame beats parity beats overrun; only a clean byte is pushed.
    always_comb begin
        rx_push = 1'b0;
        err_set = '0;
        if ((rx_state_q == RX_STOP) && rx_full_tick) begin
            if (!rx_s)                 err_set[ERR_FRAME] = 1'b1;
            else if (!rx_par_ok)       err_set[ERR_PAR]   = 1'b1;
            else if (rx_full && !rd)   err_set[ERR_OVR]   = 1'b1;
            else                       rx_push            = 1'b1;
        end
    end

    assign rx_pop = rd && !rx_empty;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            err_q <= '0;
        end else begin
            err_q <= (clr_err ? '0 : err_q) | err_set;
        end
    end

    buart_sfifo #(.W(8), .AW(RX_AW)) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_shr_q),
        .dout   (rx_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    assign tx_push = wr && !tx_full;

    buart_sfifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (tx_data),
        .dout   (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frm_q   <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frm_q   <= tx_frm_d;
        end
    end

    assign tx_load    = {1'b1, (PARITY == PARITY_NONE) ? 1'b1 : parity_bit(tx_head, PARITY),
                         tx_head, 1'b0};
    assign tx_end_bit = (tx_cnt_q == CW'(DIV - 1));
    assign tx_end_frm = tx_end_bit && (tx_bit_q == 4'(NB - 1));

    // Pop when idle, or at the end of a stop bit so queued frames follow with no gap.
    always_comb begin
        tx_pop = 1'b0;
        if (!tx_empty) begin
            if (tx_state_q == TX_IDLE)                    tx_pop = 1'b1;
            else if ((tx_state_q == TX_SHIFT) && tx_end_frm) tx_pop = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_frm_d   = tx_frm_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_pop) begin
                    tx_frm_d   = tx_load;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_end_bit) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 4'd1;
                    tx_frm_d = {1'b1, tx_frm_q[10:1]};
                    if (tx_end_frm) begin
                        tx_bit_d = '0;
                        if (tx_pop) tx_frm_d   = tx_load;
                        else        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx      = tx_frm_q[0];
    assign tx_idle = (tx_state_q == TX_IDLE) && tx_empty;
    assign busy    = tx_full;
    assign valid   = !rx_empty;
    assign err     = err_q;

endmodule

// File: tb/tb_buart_fifo_gen.sv
// Directed plus randomized bench for buart_fifo_gen: no-parity and even-parity instances at 12 clocks/bit.
module tb_buart_fifo_gen;

    localparam int unsigned FREQ  = 12;
    localparam int unsigned BAUD  = 1000000;
    localparam int unsigned DIV   = (FREQ * 1000000) / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned DEPTH = 8;
    // Edge (counted from the edge the start bit is driven after) on which the stop bit is judged:
    // 2 sync flops, 1 idle-detect cycle, HALF to mid start, then 8 data bits and the stop bit.
    localparam int unsigned STOP_EDGE = 3 + HALF + 9 * DIV;

    logic       clk, resetq;
    logic       rx0, rx1, wr0, wr1, rd0, rd1, clr0, clr1;
    logic [7:0] txd0, txd1, rxd0, rxd1;
    logic       tx0, tx1, valid0, valid1, busy0, busy1, idle0, idle1;
    logic [2:0] err0, err1;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxq[$];
    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];

    buart_fifo_gen #(.FREQ_MHZ(FREQ), .BAUDS(BAUD), .RX_AW(3), .TX_AW(3), .PARITY(0)) u_dut (
        .clk(clk), .resetq(resetq), .rx(rx0), .tx(tx0), .wr(wr0), .tx_data(txd0),
        .rd(rd0), .rx_data(rxd0), .valid(valid0), .busy(busy0), .tx_idle(idle0),
        .clr_err(clr0), .err(err0)
    );

    buart_fifo_gen #(.FREQ_MHZ(FREQ), .BAUDS(BAUD), .RX_AW(3), .TX_AW(3), .PARITY(1)) u_par (
        .clk(clk), .resetq(resetq), .rx(rx1), .tx(tx1), .wr(wr1), .tx_data(txd1),
        .rd(rd1), .rx_data(rxd1), .valid(valid1), .busy(busy1), .tx_idle(idle1),
        .clr_err(clr1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx1 = b;
        else     rx0 = b;
    endtask

    // One serial frame; sel=1 targets the even-parity instance.
    task automatic send_rx(input bit sel, input logic [7:0] d, input bit bad_par, input logic stop_v);
        logic [10:0] f;
        int n;
        if (sel) begin
            f = {stop_v, (^d) ^ bad_par, d, 1'b0};
            n = 11;
        end else begin
            f = {1'b1, stop_v, d, 1'b0};
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            drive(sel, f[i]);
            repeat (DIV) tick();
        end
        drive(sel, 1'b1);
    endtask

    task automatic pop0(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(valid0), 32'd1);
        chk({tag, "_data"}, 32'(rxd0), 32'(exp));
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
    endtask

    task automatic cmp_tx(input string tag);
        chk({tag, "_count"}, 32'(tx_got.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size(); i++) begin
            if (i < tx_got.size()) chk({tag, "_byte"}, 32'(tx_got[i]), 32'(tx_exp[i]));
        end
    endtask

    // Line-level receiver on the no-parity TX pin: mid-bit sampling from the falling start edge.
    initial begin
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (resetq && tx0 === 1'b0) begin
                repeat (HALF) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx0;
                end
                repeat (DIV) @(negedge clk);
                tx_got.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0] d;
        int cnt_m;
        bit acc, pop_m, ovr_m;

        resetq = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; txd0 = '0; txd1 = '0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_idle", 32'(idle0), 32'd1);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_tx_par", 32'(tx1), 32'd1);
        resetq = 1'b1;
        repeat (3) tick();

        // TX of 0x55: low one cycle after the pop, LSB first, DIV clocks per bit
        d = 8'h55;
        txd0 = d; wr0 = 1'b1;
        tick();
        wr0 = 1'b0;
        chk("t1_before_pop", 32'(tx0), 32'd1);
        tick();
        chk("t1_start", 32'(tx0), 32'd0);
        chk("t1_not_idle", 32'(idle0), 32'd0);
        repeat (HALF) tick();
        chk("t1_start_mid", 32'(tx0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            chk("t1_bit", 32'(tx0), 32'(d[i]));
        end
        repeat (DIV) tick();
        chk("t1_stop", 32'(tx0), 32'd1);
        repeat (10 * DIV - 1 - (HALF + 9 * DIV)) tick();
        chk("t1_idle_119", 32'(idle0), 32'd0);
        tick();
        chk("t1_idle_120", 32'(idle0), 32'd1);

        // Random TX bytes with random spacing, never filling the FIFO
        repeat (4) tick();
        tx_got.delete();
        tx_exp.delete();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            txd0 = d; wr0 = 1'b1;
            tick();
            wr0 = 1'b0;
            tx_exp.push_back(d);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (6 * 10 * DIV + 40) tick();
        cmp_tx("tx_rand");
        chk("tx_rand_idle", 32'(idle0), 32'd1);

        // RX 0xA3: valid rises right after the stop-bit sample
        d = 8'hA3;
        rx0 = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx0 = d[i];
            repeat (DIV) tick();
        end
        rx0 = 1'b1;
        repeat (STOP_EDGE - 1 - 9 * DIV) tick();
        chk("t2_valid_early", 32'(valid0), 32'd0);
        tick();
        chk("t2_valid", 32'(valid0), 32'd1);
        chk("t2_data", 32'(rxd0), 32'h0A3);
        repeat (10 * DIV - STOP_EDGE) tick();
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        chk("t2_after_rd", 32'(valid0), 32'd0);

        // Start glitch shorter than HALF is rejected
        rx0 = 1'b0;
        repeat (4) tick();
        rx0 = 1'b1;
        repeat (3 * DIV) tick();
        chk("t4_valid", 32'(valid0), 32'd0);
        chk("t4_err", 32'(err0), 32'd0);

        // Random RX frames, the first also proves the FSM recovered from the glitch
        rxq.delete();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            send_rx(1'b0, d, 1'b0, 1'b1);
            rxq.push_back(d);
            repeat ($urandom_range(0, 5)) tick();
        end
        while (rxq.size() > 0) pop0("rx_rand", rxq.pop_front());
        chk("rx_rand_empty", 32'(valid0), 32'd0);

        // rd on an empty FIFO is ignored
        rd0 = 1'b1;
        repeat (2) tick();
        rd0 = 1'b0;
        chk("rd_empty_valid", 32'(valid0), 32'd0);

        // Nine frames into an eight-deep FIFO without reading: overrun on the ninth
        ovr_m = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            send_rx(1'b0, d, 1'b0, 1'b1);
            if (rxq.size() < DEPTH) rxq.push_back(d);
            else                    ovr_m = 1'b1;
        end
        tick();
        chk("t3_err", 32'(err0), 32'({ovr_m, 2'b00}));
        while (rxq.size() > 0) pop0("t3_order", rxq.pop_front());
        chk("t3_empty", 32'(valid0), 32'd0);
        chk("t3_err_sticky", 32'(err0), 32'({ovr_m, 2'b00}));
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("t3_clr", 32'(err0), 32'd0);

        // Even parity: wrong parity bit, then a good frame, then a zero stop bit
        send_rx(1'b1, 8'h07, 1'b1, 1'b1);
        tick();
        chk("t5_par_err", 32'(err1), 32'b010);
        chk("t5_par_nostore", 32'(valid1), 32'd0);
        d = 8'($urandom);
        send_rx(1'b1, d, 1'b0, 1'b1);
        tick();
        chk("t5_good_valid", 32'(valid1), 32'd1);
        chk("t5_good_data", 32'(rxd1), 32'(d));
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        send_rx(1'b1, 8'($urandom), 1'b0, 1'b0);
        repeat (2 * DIV) tick();
        chk("t5_frame_err", 32'(err1), 32'b011);
        chk("t5_frame_nostore", 32'(valid1), 32'd0);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("t5_clr", 32'(err1), 32'd0);

        // Asynchronous reset in the middle of a TX frame
        txd0 = 8'($urandom); wr0 = 1'b1;
        tick();
        wr0 = 1'b0;
        repeat (40) tick();
        #2 resetq = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(tx0), 32'd1);
        chk("t6_rst_idle", 32'(idle0), 32'd1);
        @(posedge clk);
        #1 resetq = 1'b1;
        repeat (11 * DIV + 2) tick();
        tx_got.delete();
        chk("t6_idle_after", 32'(idle0), 32'd1);
        chk("t6_busy_after", 32'(busy0), 32'd0);

        // Ten back-to-back writes: shifter takes the first byte one cycle later, then holds for a frame
        tx_exp.delete();
        cnt_m = 0;
        for (int c = 0; c < 10; c++) begin
            d = 8'($urandom);
            chk("t6_busy", 32'(busy0), 32'(cnt_m == int'(DEPTH)));
            acc   = (cnt_m < int'(DEPTH));
            pop_m = (c == 1);
            if (acc) tx_exp.push_back(d);
            cnt_m = cnt_m + int'(acc) - int'(pop_m);
            txd0 = d; wr0 = 1'b1;
            tick();
        end
        wr0 = 1'b0;
        chk("t6_busy_end", 32'(busy0), 32'(cnt_m == int'(DEPTH)));
        repeat (tx_exp.size() * 10 * DIV + 40) tick();
        cmp_tx("t6_frames");
        chk("t6_drained", 32'(idle0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
